// File: rtl/cache_tag_sa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cache_tag_sa_pkg                                              |
// | Purpose  : Shared definitions for the set-associative tag store.         |
// |            Holds the miss/flush FSM state encodings and PLRU sizing.     |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package cache_tag_sa_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MISS  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Tree PLRU needs WAYS-1 bits; keep at least one bit so the vector
  // stays legal when the PLRU logic is not built (WAYS=1).
  function automatic int plru_w(input int ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_tag_sa_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cache_tag_sa_if                                               |
// | Purpose  : Request / refill / flush bundle of the tag store.             |
// | Ports    : master drives sram_en, sram_addr, refill_done, flush_req;     |
// |            slave drives hit, hit_way, miss, stallreq, axi_addr,          |
// |            victim_way, flush_busy.                                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface cache_tag_sa_if #(
  parameter int ADDR_W = 32,
  parameter int WAYS   = 2
);
  logic              sram_en;
  logic [ADDR_W-1:0] sram_addr;
  logic              refill_done;
  logic              flush_req;
  logic              hit;
  logic [WAYS-1:0]   hit_way;
  logic              miss;
  logic              stallreq;
  logic [ADDR_W-1:0] axi_addr;
  logic [WAYS-1:0]   victim_way;
  logic              flush_busy;

  modport master (
    output sram_en, sram_addr, refill_done, flush_req,
    input  hit, hit_way, miss, stallreq, axi_addr, victim_way, flush_busy
  );

  modport slave (
    input  sram_en, sram_addr, refill_done, flush_req,
    output hit, hit_way, miss, stallreq, axi_addr, victim_way, flush_busy
  );
endinterface
`default_nettype wire

// File: rtl/cache_tag_sa_plru.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cache_plru                                                    |
// | Purpose  : Combinational tree-PLRU for one set (WAYS = 2 or 4).          |
// |            Each bit points at the half holding the next victim           |
// |            (0 = lower half, 1 = upper half).                             |
// | Ports    : i_bits   current set PLRU bits                                |
// |            i_way    one-hot accessed way                                 |
// |            o_bits   bits with i_way marked most recently used            |
// |            o_victim one-hot victim selected by i_bits                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cache_plru #(
  parameter int WAYS   = 2,
  parameter int PLRU_W = 1
) (
  input  wire logic [PLRU_W-1:0] i_bits,
  input  wire logic [WAYS-1:0]   i_way,
  output logic      [PLRU_W-1:0] o_bits,
  output logic      [WAYS-1:0]   o_victim
);

  generate
    if (WAYS == 4) begin : g_w4
      // bit0 = root, bit1 = pair {0,1}, bit2 = pair {2,3}
      logic [1:0] w_enc;
      assign w_enc = {i_way[3] | i_way[2], i_way[3] | i_way[1]};

      always_comb begin
        o_bits = i_bits;
        if (|i_way) begin
          o_bits[0] = ~w_enc[1];
          if (w_enc[1]) o_bits[2] = ~w_enc[0];
          else          o_bits[1] = ~w_enc[0];
        end
      end

      always_comb begin
        o_victim = '0;
        case ({i_bits[0], i_bits[0] ? i_bits[2] : i_bits[1]})
          2'b00:   o_victim = 4'b0001;
          2'b01:   o_victim = 4'b0010;
          2'b10:   o_victim = 4'b0100;
          default: o_victim = 4'b1000;
        endcase
      end
    end else begin : g_w2
      // Touching way0 points the victim at way1, and vice versa.
      assign o_bits[0] = (|i_way) ? i_way[0] : i_bits[0];
      assign o_victim  = i_bits[0] ? 2'b10 : 2'b01;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/cache_tag_sa.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cache_tag_sa                                                  |
// | Purpose  : N-way set-associative tag store with tree-PLRU replacement,   |
// |            a miss FSM feeding the refill engine and a whole-cache        |
// |            invalidate sweep.                                             |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            bus (slave): request in, hit/miss/refill/flush status out     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cache_tag_sa
  import cache_tag_sa_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 7,
  parameter int OFFSET_W = 5,
  parameter int WAYS     = 2
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  cache_tag_sa_if.slave bus
);

  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS   = 1 << INDEX_W;
  localparam int PLRU_W = plru_w(WAYS);
  localparam logic [ADDR_W-1:0] c_line_mask = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  logic [TAG_W-1:0]   r_tag [WAYS][SETS];
  logic [SETS-1:0]    r_valid [WAYS];
  logic [1:0]         r_state, w_next;
  logic               r_pend;
  logic [INDEX_W-1:0] r_cnt, r_idx;
  logic [TAG_W-1:0]   r_tagl;
  logic [WAYS-1:0]    r_victim;

  logic [TAG_W-1:0]   w_req_tag;
  logic [INDEX_W-1:0] w_req_idx;
  logic [WAYS-1:0]    w_match, w_invalid, w_first_inv, w_plru_victim, w_new_victim;
  logic               w_lookup, w_hit, w_refill;

  assign w_req_tag = bus.sram_addr[ADDR_W-1 -: TAG_W];
  assign w_req_idx = bus.sram_addr[OFFSET_W +: INDEX_W];

  generate
    for (genvar w = 0; w < WAYS; w++) begin : g_way
      assign w_match[w]   = r_valid[w][w_req_idx] && (r_tag[w][w_req_idx] == w_req_tag);
      assign w_invalid[w] = ~r_valid[w][w_req_idx];
    end
  endgenerate

  assign w_lookup = bus.sram_en && (r_state == ST_IDLE);
  assign w_hit    = w_lookup && (|w_match);
  assign w_refill = (r_state == ST_MISS) && bus.refill_done;

  // Isolate the lowest set bit: fill empty ways in order before evicting.
  assign w_first_inv  = w_invalid & (~w_invalid + WAYS'(1));
  assign w_new_victim = (|w_invalid) ? w_first_inv : w_plru_victim;

  generate
    if (WAYS > 1) begin : g_plru
      logic [PLRU_W-1:0]  r_plru [SETS];
      logic [INDEX_W-1:0] w_idx;
      logic [WAYS-1:0]    w_acc_way;
      logic [PLRU_W-1:0]  w_upd;

      // In MISS the refill touches the latched set; otherwise the request set.
      assign w_idx     = (r_state == ST_MISS) ? r_idx : w_req_idx;
      assign w_acc_way = (r_state == ST_MISS) ? r_victim : w_match;

      cache_plru #(.WAYS(WAYS), .PLRU_W(PLRU_W)) u_plru (
        .i_bits   (r_plru[w_idx]),
        .i_way    (w_acc_way),
        .o_bits   (w_upd),
        .o_victim (w_plru_victim)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
        end else if (r_state == ST_FLUSH) begin
          r_plru[r_cnt] <= '0;
        end else if (w_refill) begin
          r_plru[r_idx] <= w_upd;
        end else if (w_hit) begin
          r_plru[w_req_idx] <= w_upd;
        end
      end
    end else begin : g_no_plru
      assign w_plru_victim = 1'b1;
    end
  endgenerate

  // Tag RAM carries no reset; validity alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (w_refill) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_victim[w]) r_tag[w][r_idx] <= r_tagl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
    end else if (r_state == ST_FLUSH) begin
      for (int w = 0; w < WAYS; w++) r_valid[w][r_cnt] <= 1'b0;
    end else if (w_refill) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_victim[w]) r_valid[w][r_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= 1'b0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_tagl   <= '0;
      r_victim <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_lookup && !w_hit && !bus.flush_req) begin
            r_tagl   <= w_req_tag;
            r_idx    <= w_req_idx;
            r_victim <= w_new_victim;
          end
        end
        ST_MISS: begin
          if (bus.refill_done)    r_pend <= 1'b0;
          else if (bus.flush_req) r_pend <= 1'b1;
        end
        ST_FLUSH: r_cnt <= r_cnt + 1'b1;  // wraps to 0 on the last set
        default: ;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.flush_req)          w_next = ST_FLUSH;
        else if (w_lookup && !w_hit) w_next = ST_MISS;
      end
      ST_MISS: begin
        // A flush arriving on the refill cycle itself is honoured too.
        if (bus.refill_done) w_next = (r_pend || bus.flush_req) ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: begin
        if (r_cnt == '1) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.hit        = w_hit;
    bus.hit_way    = w_hit ? w_match : '0;
    bus.miss       = (r_state == ST_MISS) || (w_lookup && !w_hit);
    bus.flush_busy = (r_state == ST_FLUSH);
    bus.stallreq   = bus.miss || bus.flush_busy;
    bus.victim_way = r_victim;
    bus.axi_addr   = bus.sram_addr & c_line_mask;
    if (r_state == ST_MISS) bus.axi_addr = {r_tagl, r_idx, {OFFSET_W{1'b0}}};
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_tag_sa.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cache_tag_sa                                               |
// | Purpose  : Directed self-checking bench for cache_tag_sa (2-way,         |
// |            128 sets, 32-byte lines).                                     |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_cache_tag_sa;

  localparam int ADDR_W = 32;
  localparam int WAYS   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cache_tag_sa_if #(.ADDR_W(ADDR_W), .WAYS(WAYS)) bus ();

  cache_tag_sa #(.ADDR_W(ADDR_W), .INDEX_W(7), .OFFSET_W(5), .WAYS(WAYS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.sram_en = 0; bus.sram_addr = '0; bus.refill_done = 0; bus.flush_req = 0;
    #3;
    n_tests++; if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL rst_hit got %b exp 0", bus.hit); end
    n_tests++; if (bus.hit_way !== 2'b00) begin n_fail++; $display("FAIL rst_hit_way got %b exp 00", bus.hit_way); end
    n_tests++; if (bus.flush_busy !== 1'b0) begin n_fail++; $display("FAIL rst_flush_busy got %b exp 0", bus.flush_busy); end
    n_tests++; if (bus.victim_way !== 2'b00) begin n_fail++; $display("FAIL rst_victim got %b exp 00", bus.victim_way); end
    n_tests++; if ({bus.miss, bus.stallreq} !== 2'b00) begin n_fail++; $display("FAIL rst_miss_en0 got %b exp 00", {bus.miss, bus.stallreq}); end
    bus.sram_en = 1; bus.sram_addr = 32'h0000_0040; #1;
    n_tests++; if ({bus.miss, bus.stallreq} !== 2'b11) begin n_fail++; $display("FAIL rst_miss_en1 got %b exp 11", {bus.miss, bus.stallreq}); end
    bus.sram_en = 0;
    tick; tick;
    rst_n = 1;
  endtask

  task automatic test_first_miss;
    tick;
    bus.sram_en = 1; bus.sram_addr = 32'h1FC0_0004; #1;
    n_tests++; if ({bus.miss, bus.stallreq, bus.hit} !== 3'b110) begin n_fail++; $display("FAIL t1_miss got %b exp 110", {bus.miss, bus.stallreq, bus.hit}); end
    n_tests++; if (bus.axi_addr !== 32'h1FC0_0000) begin n_fail++; $display("FAIL t1_axi_idle got %h exp 1fc00000", bus.axi_addr); end
    tick;
    bus.sram_addr = 32'h1234_5678; #1;
    n_tests++; if (bus.victim_way !== 2'b01) begin n_fail++; $display("FAIL t1_victim got %b exp 01", bus.victim_way); end
    n_tests++; if (bus.axi_addr !== 32'h1FC0_0000) begin n_fail++; $display("FAIL t1_axi_miss got %h exp 1fc00000", bus.axi_addr); end
    n_tests++; if ({bus.miss, bus.hit} !== 2'b10) begin n_fail++; $display("FAIL t1_in_miss got %b exp 10", {bus.miss, bus.hit}); end
    bus.refill_done = 1;
    tick;
    bus.refill_done = 0; bus.sram_addr = 32'h1FC0_0004; #1;
    n_tests++; if ({bus.hit, bus.hit_way, bus.miss} !== 4'b1010) begin n_fail++; $display("FAIL t1_hit got %b exp 1010", {bus.hit, bus.hit_way, bus.miss}); end
  endtask

  task automatic test_two_way_fill;
    tick;
    bus.sram_addr = 32'h0000_0040; #1;
    n_tests++; if (bus.miss !== 1'b1) begin n_fail++; $display("FAIL t2_miss_a got %b exp 1", bus.miss); end
    tick;
    n_tests++; if (bus.victim_way !== 2'b01) begin n_fail++; $display("FAIL t2_victim_a got %b exp 01", bus.victim_way); end
    bus.refill_done = 1; tick; bus.refill_done = 0;
    bus.sram_addr = 32'h0000_1040; #1;
    n_tests++; if (bus.miss !== 1'b1) begin n_fail++; $display("FAIL t2_miss_b got %b exp 1", bus.miss); end
    tick;
    n_tests++; if (bus.victim_way !== 2'b10) begin n_fail++; $display("FAIL t2_victim_b got %b exp 10", bus.victim_way); end
    bus.refill_done = 1; tick; bus.refill_done = 0;
    bus.sram_addr = 32'h0000_0040; #1;
    n_tests++; if ({bus.hit, bus.hit_way} !== 3'b101) begin n_fail++; $display("FAIL t2_hit_a got %b exp 101", {bus.hit, bus.hit_way}); end
    tick;
    bus.sram_addr = 32'h0000_1040; #1;
    n_tests++; if ({bus.hit, bus.hit_way} !== 3'b110) begin n_fail++; $display("FAIL t2_hit_b got %b exp 110", {bus.hit, bus.hit_way}); end
  endtask

  task automatic test_plru_evict;
    tick;
    bus.sram_addr = 32'h0000_0040; #1;
    n_tests++; if ({bus.hit, bus.hit_way} !== 3'b101) begin n_fail++; $display("FAIL t3_hit_a got %b exp 101", {bus.hit, bus.hit_way}); end
    tick;
    bus.sram_addr = 32'h0000_2040; #1;
    n_tests++; if (bus.miss !== 1'b1) begin n_fail++; $display("FAIL t3_miss_c got %b exp 1", bus.miss); end
    tick;
    n_tests++; if (bus.victim_way !== 2'b10) begin n_fail++; $display("FAIL t3_victim_c got %b exp 10", bus.victim_way); end
    bus.refill_done = 1; tick; bus.refill_done = 0;
    bus.sram_addr = 32'h0000_0040; #1;
    n_tests++; if ({bus.hit, bus.hit_way} !== 3'b101) begin n_fail++; $display("FAIL t3_keep_a got %b exp 101", {bus.hit, bus.hit_way}); end
    tick;
    bus.sram_addr = 32'h0000_1040; #1;
    n_tests++; if ({bus.hit, bus.miss} !== 2'b01) begin n_fail++; $display("FAIL t3_evicted_b got %b exp 01", {bus.hit, bus.miss}); end
    bus.sram_en = 0;
  endtask

  task automatic test_flush_idle;
    int  cnt  = 0;
    bit  done = 0;
    tick;
    bus.flush_req = 1;
    tick;
    bus.flush_req = 0;
    bus.sram_en = 1; bus.sram_addr = 32'h0000_0040; #1;
    n_tests++; if ({bus.flush_busy, bus.stallreq, bus.hit, bus.miss} !== 4'b1100) begin n_fail++; $display("FAIL t4_flush_outs got %b exp 1100", {bus.flush_busy, bus.stallreq, bus.hit, bus.miss}); end
    for (int i = 0; i < 300 && !done; i++) begin
      if (bus.flush_busy) begin cnt++; tick; end
      else done = 1;
    end
    n_tests++; if (!done || cnt != 128) begin n_fail++; $display("FAIL t4_flush_len got %0d cycles (ended=%0b) exp 128", cnt, done); end
    n_tests++; if (bus.miss !== 1'b1) begin n_fail++; $display("FAIL t4_post_miss got %b exp 1", bus.miss); end
    tick;
    n_tests++; if (bus.victim_way !== 2'b01) begin n_fail++; $display("FAIL t4_post_victim got %b exp 01", bus.victim_way); end
    bus.refill_done = 1; tick; bus.refill_done = 0;
  endtask

  task automatic test_flush_in_miss;
    int  cnt  = 0;
    bit  done = 0;
    bus.sram_addr = 32'h0000_3040; #1;
    n_tests++; if (bus.miss !== 1'b1) begin n_fail++; $display("FAIL t5_miss got %b exp 1", bus.miss); end
    tick;
    bus.flush_req = 1; tick; bus.flush_req = 0;
    n_tests++; if ({bus.miss, bus.flush_busy, bus.victim_way} !== 4'b1010) begin n_fail++; $display("FAIL t5_pending got %b exp 1010", {bus.miss, bus.flush_busy, bus.victim_way}); end
    bus.refill_done = 1; tick; bus.refill_done = 0;
    n_tests++; if ({bus.flush_busy, bus.miss, bus.hit} !== 3'b100) begin n_fail++; $display("FAIL t5_flush_start got %b exp 100", {bus.flush_busy, bus.miss, bus.hit}); end
    for (int i = 0; i < 300 && !done; i++) begin
      if (bus.flush_busy) begin cnt++; tick; end
      else done = 1;
    end
    n_tests++; if (!done || cnt != 128) begin n_fail++; $display("FAIL t5_flush_len got %0d cycles (ended=%0b) exp 128", cnt, done); end
    n_tests++; if ({bus.hit, bus.miss} !== 2'b01) begin n_fail++; $display("FAIL t5_line_gone got %b exp 01", {bus.hit, bus.miss}); end
    bus.sram_en = 0;
  endtask

  task automatic test_async_reset;
    tick;
    bus.sram_en = 1; bus.sram_addr = 32'h1FC0_0004;
    tick;
    bus.refill_done = 1; tick; bus.refill_done = 0;
    n_tests++; if (bus.hit !== 1'b1) begin n_fail++; $display("FAIL t6_fill got %b exp 1", bus.hit); end
    bus.sram_addr = 32'h0000_5000;
    tick;
    n_tests++; if ({bus.miss, bus.victim_way} !== 3'b110) begin n_fail++; $display("FAIL t6_in_miss got %b exp 110", {bus.miss, bus.victim_way}); end
    #1 rst_n = 0; #1;
    n_tests++; if ({bus.miss, bus.stallreq, bus.victim_way, bus.flush_busy} !== 5'b11000) begin n_fail++; $display("FAIL t6_rst_outs got %b exp 11000", {bus.miss, bus.stallreq, bus.victim_way, bus.flush_busy}); end
    n_tests++; if (bus.axi_addr !== 32'h0000_5000) begin n_fail++; $display("FAIL t6_rst_axi got %h exp 00005000", bus.axi_addr); end
    bus.sram_en = 0; #1;
    n_tests++; if ({bus.miss, bus.stallreq} !== 2'b00) begin n_fail++; $display("FAIL t6_rst_follow got %b exp 00", {bus.miss, bus.stallreq}); end
    rst_n = 1;
    tick;
    bus.sram_en = 1; bus.sram_addr = 32'h1FC0_0004; #1;
    n_tests++; if ({bus.hit, bus.miss} !== 2'b01) begin n_fail++; $display("FAIL t6_valid_lost got %b exp 01", {bus.hit, bus.miss}); end
    bus.sram_en = 0;
  endtask

  initial begin
    test_reset;
    test_first_miss;
    test_two_way_fill;
    test_plru_evict;
    test_flush_idle;
    test_flush_in_miss;
    test_async_reset;
    tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
